logdrop_window_accum: RTL and testbench
=======================================

Name: logdrop_window_accum

Overview:
- Sequencer and accumulator wrapped around the combinational logdropWindow datapath.
- Accepts a valid/ready sample stream and drives the datapath's i_t from an internal window-position counter.
- Sums the windowed outputs over WINLEN samples and presents each completed window sum on a valid/ready result port.
- Used wherever a log-drop-weighted windowed sum is needed, e.g. correlator and rate-estimate pipelines.

Parameters:
- DATA_W, 8, sample width; passed to logdropWindow.
- WINLEN, 64, window length in samples; power of 2, at least 2; passed to logdropWindow.
- ABSTRACT_MODEL, 0, passed through to the logdropWindow instance.
- Derived, not overridable: T_W = $clog2(WINLEN); SUM_W = DATA_W + T_W.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_cg  input  1  clock gate; when 0, no register updates and no transfers complete.
- i_clear  input  1  synchronous restart of the current window.
- i_x  input  DATA_W  sample.
- i_xValid  input  1  sample valid.
- o_xReady  output  1  sample ready.
- o_t  output  T_W  window position of the next sample to be accepted.
- o_sum  output  SUM_W  completed window sum.
- o_sumValid  output  1  o_sum valid.
- i_sumReady  input  1  consumer ready for o_sum.

Behaviour:
- Reset values: o_t=0, o_sum=0, o_sumValid=0, internal accumulator acc=0. o_xReady=1 once out of reset.
- Datapath hookup: one logdropWindow instance, i_t=o_t, i_x=i_x, combinational output y.
- Sample transfer: xAcc = i_cg & i_xValid & o_xReady.
- Result transfer: sAcc = i_cg & o_sumValid & i_sumReady.
- On xAcc with o_t < WINLEN-1:
  - acc <= acc + y.
  - o_t <= o_t+1.
- On xAcc with o_t == WINLEN-1 (window complete):
  - o_sum <= acc + y.
  - o_sumValid <= 1.
  - acc <= 0.
  - o_t <= 0, wrapping with no gap cycle.
- Latency: o_sum/o_sumValid update on the clock edge that accepts the last sample of the window.
- On sAcc with no simultaneous completion: o_sumValid <= 0, and o_sum holds its value.
- Simultaneous sAcc and completion: the new sum is loaded and o_sumValid stays 1; no bubble.
- Back-pressure:
  - o_xReady = !(o_sumValid & !i_sumReady & (o_t == WINLEN-1)).
  - Accumulation of the next window continues while a result is held; the block stalls only on the final sample of the next window.
  - This gives a combinational path from i_sumReady to o_xReady, which is permitted.
- Overflow: none possible. y <= 2^DATA_W-1 and there are WINLEN terms, so the sum fits in SUM_W.
- i_clear (acts only when i_cg=1): acc <= 0 and o_t <= 0. It overrides any same-cycle xAcc, and the sample is discarded. o_sum/o_sumValid are unaffected and sAcc is still honoured.
- Priority: i_rst > i_cg=0 > i_clear > xAcc.
- Reset asserted mid-window or with a result pending: everything returns to reset values immediately and the pending result is lost.
- o_sum and o_sumValid must be stable while o_sumValid=1 and i_sumReady=0.
- No combinational path from i_x to any output.

Test Plan:
1. Reset, then WINLEN=64 back-to-back samples x=0 with i_sumReady=1 -> o_t counts 0..63 then 0; o_sumValid high exactly 1 cycle after the 64th transfer; o_sum=0.
2. 64 samples x=8'hFF with i_sumReady=1 -> o_sum equals the bench sum of abstract logdropWindow(t, 8'hFF) for t=0..63; the B config (DATA_W=5, WINLEN=16) is checked likewise against its model.
3. i_sumReady=0 after a first window, then 63 more samples -> all accepted; on the 64th, o_xReady=0 and o_t stays 63. Raising i_sumReady -> first sum consumed and second loaded on the same edge, with o_sumValid staying 1.
4. Assert i_clear after 10 samples, concurrently with i_xValid -> o_t=0 next cycle; the cleared-cycle sample is not counted. The next 64 samples yield the model sum of those 64 only.
5. Hold i_cg=0 for 5 cycles mid-window with i_xValid=1 -> o_t, acc and o_sum are unchanged. Transfers resume when i_cg=1.
6. Assert i_rst asynchronously (mid-cycle) at o_t=37 with o_sumValid=1 -> o_t=0, o_sumValid=0, o_sum=0 before the next clock edge. A full window after release gives the correct sum.

Source files
------------

// File: rtl/logdrop_window_accum.sv
// Windowed accumulator around the logdropWindow datapath. The sample at window position t is
// weighted by 2^-floor(log2(t+1)), and each completed window sum is offered on a valid/ready port.

module logdropWindow #(
    parameter int DATA_W         = 8,
    parameter int WINLEN         = 64,
    parameter int ABSTRACT_MODEL = 0,
    localparam int T_W           = $clog2(WINLEN)
) (
    input  logic [T_W-1:0]    i_t,
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_y
);
    logic [T_W:0] w_tp1;

    assign w_tp1 = {1'b0, i_t} + (T_W + 1)'(1);

    generate
        if (ABSTRACT_MODEL != 0) begin : g_abstract
            logic [31:0] w_div;

            always_comb begin
                w_div = 32'd1;
                for (int k = 1; k <= T_W; k++) begin
                    if (32'(w_tp1) >= (32'd1 << k)) w_div = 32'd1 << k;
                end
                o_y = DATA_W'(32'(i_x) / w_div);
            end
        end else begin : g_struct
            logic [31:0] w_shift;

            // The shift is the position of the leading one of t+1.
            always_comb begin
                w_shift = '0;
                for (int k = 0; k <= T_W; k++) begin
                    if (w_tp1[k]) w_shift = 32'(k);
                end
            end

            assign o_y = i_x >> w_shift;
        end
    endgenerate
endmodule

module logdrop_window_accum #(
    parameter int DATA_W         = 8,
    parameter int WINLEN         = 64,
    parameter int ABSTRACT_MODEL = 0,
    localparam int T_W           = $clog2(WINLEN),
    localparam int SUM_W         = DATA_W + T_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_x,
    input  logic              i_xValid,
    output logic              o_xReady,
    output logic [T_W-1:0]    o_t,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_sumValid,
    input  logic              i_sumReady
);
    logic [T_W-1:0]    r_t;
    logic [SUM_W-1:0]  r_acc;
    logic [SUM_W-1:0]  r_sum;
    logic              r_sum_valid;
    logic [DATA_W-1:0] w_y;
    logic [SUM_W-1:0]  w_acc_next;
    logic              w_last;
    logic              w_x_acc;
    logic              w_s_acc;

    logdropWindow #(
        .DATA_W         (DATA_W),
        .WINLEN         (WINLEN),
        .ABSTRACT_MODEL (ABSTRACT_MODEL)
    ) u_window (
        .i_t (r_t),
        .i_x (i_x),
        .o_y (w_y)
    );

    assign w_last     = (r_t == T_W'(WINLEN - 1));
    assign w_acc_next = r_acc + SUM_W'(w_y);
    // Stall only the final sample of a window while the previous result is still unclaimed.
    assign o_xReady   = !(r_sum_valid && !i_sumReady && w_last);
    assign w_x_acc    = i_cg && i_xValid && o_xReady;
    assign w_s_acc    = i_cg && r_sum_valid && i_sumReady;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_t         <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else if (i_cg) begin
            if (w_s_acc) r_sum_valid <= 1'b0;
            if (i_clear) begin
                r_t   <= '0;
                r_acc <= '0;
            end else if (w_x_acc) begin
                if (w_last) begin
                    // A completion on the same edge as a consume reloads the result with no bubble.
                    r_sum       <= w_acc_next;
                    r_sum_valid <= 1'b1;
                    r_acc       <= '0;
                    r_t         <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_t   <= r_t + T_W'(1);
                end
            end
        end
    end

    assign o_t        = r_t;
    assign o_sum      = r_sum;
    assign o_sumValid = r_sum_valid;
endmodule

// File: tb/tb_logdrop_window_accum.sv
// Randomized scoreboard bench for logdrop_window_accum: a 64-sample/8-bit instance under directed
// scenarios, plus a 16-sample/5-bit instance under free-running random traffic.

module tb_logdrop_window_accum;
    localparam int DW  = 8;
    localparam int WL  = 64;
    localparam int DWB = 5;
    localparam int WLB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cg = 1'b1, clear = 1'b0, x_valid = 1'b0, sum_ready = 1'b1;
    logic [DW-1:0] x = '0;
    logic          x_ready, sum_valid;
    logic [5:0]    t;
    logic [13:0]   sum;

    logic           cg_b = 1'b1, clear_b = 1'b0, x_valid_b = 1'b0, sum_ready_b = 1'b1;
    logic [DWB-1:0] x_b = '0;
    logic           x_ready_b, sum_valid_b;
    logic [3:0]     t_b;
    logic [8:0]     sum_b;
    bit             run_b = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    logdrop_window_accum #(.DATA_W(DW), .WINLEN(WL), .ABSTRACT_MODEL(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_clear(clear), .i_x(x), .i_xValid(x_valid),
        .o_xReady(x_ready), .o_t(t), .o_sum(sum), .o_sumValid(sum_valid), .i_sumReady(sum_ready)
    );

    logdrop_window_accum #(.DATA_W(DWB), .WINLEN(WLB), .ABSTRACT_MODEL(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_cg(cg_b), .i_clear(clear_b), .i_x(x_b), .i_xValid(x_valid_b),
        .o_xReady(x_ready_b), .o_t(t_b), .o_sum(sum_b), .o_sumValid(sum_valid_b),
        .i_sumReady(sum_ready_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Weight of position t is 1/2^floor(log2(t+1)), integer-truncated.
    function automatic int ldw(input int pos, input int val);
        int p = pos + 1;
        int d = 1;
        while (p > 1) begin
            p = p / 2;
            d = d * 2;
        end
        return val / d;
    endfunction

    // Reference model and monitor for the main instance; inputs change only just after posedge.
    int win_q[$];
    int exp_q[$];
    int last_sum = 0;

    always @(negedge clk) begin
        bit pend, exp_ready;
        int s, front;
        if (rst) begin
            win_q.delete();
            exp_q.delete();
            last_sum = 0;
        end else begin
            pend      = exp_q.size() > 0;
            exp_ready = !(pend && !sum_ready && win_q.size() == WL - 1);
            check("o_t", t, win_q.size());
            check("o_sumValid", sum_valid, pend);
            check("o_sum_held", sum, last_sum);
            check("o_xReady", x_ready, exp_ready);
            if (cg) begin
                if (pend && sum_ready) begin
                    front = exp_q.pop_front();
                    check("result", sum, front);
                end
                if (clear) win_q.delete();
                else if (x_valid && exp_ready) begin
                    win_q.push_back(ldw(win_q.size(), int'(x)));
                    if (win_q.size() == WL) begin
                        s = win_q.sum();
                        exp_q.push_back(s);
                        last_sum = s;
                        win_q.delete();
                    end
                end
            end
        end
    end

    // Reference model and monitor for the small instance.
    int win_b[$];
    int exp_b[$];

    always @(negedge clk) begin
        bit pend, exp_ready;
        int s, front;
        if (rst) begin
            win_b.delete();
            exp_b.delete();
        end else begin
            pend      = exp_b.size() > 0;
            exp_ready = !(pend && !sum_ready_b && win_b.size() == WLB - 1);
            check("b_o_t", t_b, win_b.size());
            check("b_o_sumValid", sum_valid_b, pend);
            check("b_o_xReady", x_ready_b, exp_ready);
            if (pend && sum_ready_b) begin
                front = exp_b.pop_front();
                check("b_result", sum_b, front);
            end
            if (x_valid_b && exp_ready) begin
                win_b.push_back(ldw(win_b.size(), int'(x_b)));
                if (win_b.size() == WLB) begin
                    s = win_b.sum();
                    exp_b.push_back(s);
                    win_b.delete();
                end
            end
        end
    end

    initial begin
        @(negedge rst);
        while (run_b) begin
            @(posedge clk);
            #1;
            x_valid_b   = ($urandom_range(0, 3) != 0);
            x_b         = DWB'($urandom);
            sum_ready_b = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic send(input logic [DW-1:0] v);
        bit taken;
        x       = v;
        x_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            taken = x_ready && cg && !clear;
            @(posedge clk);
            #1;
            if (taken) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_o_t", t, 0);
        check("rst_o_sumValid", sum_valid, 0);
        check("rst_o_sum", sum, 0);
        check("rst_o_xReady", x_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero window, then saturated window.
        for (int i = 0; i < WL; i++) send('0);
        idle(3);
        for (int i = 0; i < WL; i++) send(8'hFF);
        idle(3);

        // Held result; next window stalls on its last sample, then no-bubble handoff.
        sum_ready = 1'b0;
        for (int i = 0; i < 2 * WL - 1; i++) send(DW'($urandom));
        x       = DW'($urandom);
        x_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stall_o_t", t, WL - 1);
        check("stall_o_xReady", x_ready, 0);
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        check("handoff_o_sumValid", sum_valid, 1);
        check("handoff_o_t", t, 0);
        idle(3);

        // Clear with a concurrent sample.
        for (int i = 0; i < 10; i++) send(DW'($urandom));
        x       = DW'($urandom);
        x_valid = 1'b1;
        clear   = 1'b1;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        x_valid = 1'b0;
        check("clear_o_t", t, 0);
        for (int i = 0; i < WL; i++) send(DW'($urandom));
        idle(3);

        // Clock gate held low mid-window.
        for (int i = 0; i < 20; i++) send(DW'($urandom));
        cg      = 1'b0;
        x       = DW'($urandom);
        x_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("gated_o_t", t, 20);
        cg = 1'b1;
        for (int i = 0; i < WL - 20; i++) send(DW'($urandom));
        idle(3);

        // Asynchronous reset with a pending result at o_t=37.
        sum_ready = 1'b0;
        for (int i = 0; i < WL + 37; i++) send(DW'($urandom));
        x_valid = 1'b0;
        check("pre_rst_o_t", t, 37);
        check("pre_rst_o_sumValid", sum_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_o_t", t, 0);
        check("async_rst_o_sumValid", sum_valid, 0);
        check("async_rst_o_sum", sum, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sum_ready = 1'b1;
        for (int i = 0; i < WL; i++) send(DW'($urandom));
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);

        run_b = 1'b0;
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
